// File: rtl/vga_reg_writer.sv
// vga_reg_writer: keeps a shadow of the VGA sprite peripheral's register map
// and flushes the dirty entries once per frame as single-cycle Avalon-MM
// writes, starting after the falling edge of VGA vertical sync.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a vsync falling edge; no bus activity
// SCAN  | visiting idx 0..NUM_REGS-1, one per cycle, writing dirty ones
module vga_reg_writer #(
    parameter int NUM_REGS = 12,
    parameter int DATA_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              upd_valid,
    output logic              upd_ready,
    input  logic [3:0]        upd_addr,
    input  logic [DATA_W-1:0] upd_data,
    input  logic              force_all,
    input  logic              vga_vs,
    output logic              chipselect,
    output logic              write,
    output logic [8:0]        address,
    output logic [31:0]       writedata,
    output logic              busy,
    output logic [7:0]        bad_addr_cnt,
    output logic [7:0]        overrun_cnt
);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t            state;
    logic [3:0]        idx;
    logic              vs_d;
    logic              vs_fall;
    logic [DATA_W-1:0] shadow [NUM_REGS];
    logic [NUM_REGS-1:0] dirty;
    logic [DATA_W-1:0] cur_data;
    logic              cur_dirty;
    logic              upd_fire;
    logic              addr_ok;

    // Peripheral power-on values, truncated to 8 bits.
    function automatic logic [DATA_W-1:0] reset_value(input int i);
        logic [7:0] v;
        case (i)
            0:       v = 8'd100;
            1:       v = 8'd100;
            2:       v = 8'd200;
            3:       v = 8'd150;
            4:       v = 8'd44;
            5:       v = 8'd200;
            6:       v = 8'd244;
            7:       v = 8'd100;
            8:       v = 8'd100;
            9:       v = 8'd4;
            10:      v = 8'd160;
            11:      v = 8'd192;
            default: v = 8'd0;
        endcase
        return DATA_W'(v);
    endfunction

    // Game logic may always push updates except while held in reset.
    assign upd_ready = ~reset;
    assign upd_fire  = upd_valid & upd_ready;
    assign addr_ok   = ({1'b0, upd_addr} < 5'(NUM_REGS));

    // Select the shadow entry and dirty flag for the index being scanned.
    always_comb begin
        cur_data  = '0;
        cur_dirty = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx == 4'(i)) begin
                cur_data  = shadow[i];
                cur_dirty = dirty[i];
            end
        end
    end

    // Shadow and dirty bookkeeping; a new update or force_all wins over the
    // scan's clear so a value landing on the scanned index goes out next frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow[i] <= reset_value(i);
            end
            dirty <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (force_all || (upd_fire && addr_ok && upd_addr == 4'(i))) begin
                    dirty[i] <= 1'b1;
                end else if (state == SCAN && idx == 4'(i)) begin
                    dirty[i] <= 1'b0;
                end
                if (upd_fire && addr_ok && upd_addr == 4'(i)) begin
                    shadow[i] <= upd_data;
                end
            end
        end
    end

    // Vsync edge pipeline, scan FSM, registered bus outputs and error counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            idx          <= '0;
            vs_d         <= 1'b1;
            vs_fall      <= 1'b0;
            chipselect   <= 1'b0;
            write        <= 1'b0;
            address      <= '0;
            writedata    <= '0;
            busy         <= 1'b0;
            bad_addr_cnt <= '0;
            overrun_cnt  <= '0;
        end else begin
            vs_d       <= vga_vs;
            vs_fall    <= vs_d & ~vga_vs;
            chipselect <= 1'b0;
            write      <= 1'b0;

            if (upd_fire && !addr_ok && bad_addr_cnt != 8'hFF) begin
                bad_addr_cnt <= bad_addr_cnt + 8'd1;
            end

            case (state)
                IDLE: begin
                    if (vs_fall) begin
                        state <= SCAN;
                        busy  <= 1'b1;
                        idx   <= '0;
                    end
                end
                SCAN: begin
                    chipselect <= cur_dirty;
                    write      <= cur_dirty;
                    address    <= 9'(idx);
                    writedata  <= {{(32-DATA_W){1'b0}}, cur_data};
                    if (vs_fall && overrun_cnt != 8'hFF) begin
                        overrun_cnt <= overrun_cnt + 8'd1;
                    end
                    if (idx == 4'(NUM_REGS-1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        idx   <= '0;
                    end else begin
                        idx <= idx + 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_reg_writer.sv
// Bench for vga_reg_writer: frame-level reference model plus directed
// scenarios pinned to hand-computed write timing and data.
module tb_vga_reg_writer;

    localparam int N = 12;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        upd_valid = 1'b0;
    logic        upd_ready;
    logic [3:0]  upd_addr = '0;
    logic [7:0]  upd_data = '0;
    logic        force_all = 1'b0;
    logic        vga_vs = 1'b1;
    logic        chipselect;
    logic        write;
    logic [8:0]  address;
    logic [31:0] writedata;
    logic        busy;
    logic [7:0]  bad_addr_cnt;
    logic [7:0]  overrun_cnt;

    always #5 clk = ~clk;

    vga_reg_writer #(.NUM_REGS(N), .DATA_W(8)) dut (
        .clk(clk), .reset(reset),
        .upd_valid(upd_valid), .upd_ready(upd_ready),
        .upd_addr(upd_addr), .upd_data(upd_data),
        .force_all(force_all), .vga_vs(vga_vs),
        .chipselect(chipselect), .write(write),
        .address(address), .writedata(writedata),
        .busy(busy), .bad_addr_cnt(bad_addr_cnt), .overrun_cnt(overrun_cnt)
    );

    int checks = 0;
    int errors = 0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endfunction

    logic [7:0] defaults [N] = '{8'd100, 8'd100, 8'd200, 8'd150, 8'd44, 8'd200,
                                 8'd244, 8'd100, 8'd100, 8'd4, 8'd160, 8'd192};

    // Reference model: a detected vsync edge at edge E opens a scan window
    // starting at S=E+1; index k is written at edge S+1+k, busy spans S..S+11.
    logic [7:0] m_sh [N];
    bit         m_dt [N];
    bit         m_vsp, m_det, in_scan, started;
    int         m_start, k, cyc;
    bit         e_cs, e_busy;
    int         e_addr, e_bad, e_ovr;
    logic [7:0] e_data;

    always @(posedge clk) begin
        cyc++;
        started = 1'b1;
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                m_sh[i] = defaults[i];
                m_dt[i] = 1'b0;
            end
            m_vsp = 1'b1; m_det = 1'b0; m_start = -1000;
            e_cs = 1'b0; e_busy = 1'b0; e_bad = 0; e_ovr = 0;
            e_addr = 0; e_data = '0;
        end else begin
            in_scan = (cyc >= m_start + 1) && (cyc <= m_start + 12);
            k = cyc - m_start - 1;
            e_cs = 1'b0;
            if (in_scan) begin
                e_cs = m_dt[k];
                e_addr = k;
                e_data = m_sh[k];
                m_dt[k] = 1'b0;
            end
            if (m_det) begin
                if (in_scan) e_ovr = (e_ovr == 255) ? 255 : e_ovr + 1;
                else m_start = cyc;
            end
            e_busy = (cyc >= m_start) && (cyc <= m_start + 11);
            if (force_all) for (int i = 0; i < N; i++) m_dt[i] = 1'b1;
            if (upd_valid) begin
                if (int'(upd_addr) < N) begin
                    m_sh[upd_addr] = upd_data;
                    m_dt[upd_addr] = 1'b1;
                end else begin
                    e_bad = (e_bad == 255) ? 255 : e_bad + 1;
                end
            end
            m_det = m_vsp && !vga_vs;
            m_vsp = vga_vs;
        end
    end

    typedef struct { int cyc; int addr; logic [31:0] data; } wr_t;
    wr_t wlog[$];
    int  busy_total = 0;

    // Per-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        if (started) begin
            chk("upd_ready", upd_ready, !reset);
            chk("chipselect", chipselect, e_cs);
            chk("write", write, e_cs);
            chk("busy", busy, e_busy);
            chk("bad_addr_cnt", bad_addr_cnt, e_bad);
            chk("overrun_cnt", overrun_cnt, e_ovr);
            if (e_cs) begin
                chk("address", address, e_addr);
                chk("writedata", writedata, {24'b0, e_data});
            end
            if (chipselect === 1'b1) wlog.push_back('{cyc, int'(address), writedata});
            if (busy === 1'b1) busy_total++;
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; upd_valid = 1'b0; force_all = 1'b0; vga_vs = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(2);
    endtask

    task automatic upd(int a, int d);
        upd_valid = 1'b1; upd_addr = 4'(a); upd_data = 8'(d);
        tick(1);
        upd_valid = 1'b0;
    endtask

    task automatic vsync(output int e);
        vga_vs = 1'b0;
        e = cyc + 1;
        tick(3);
        vga_vs = 1'b1;
    endtask

    task automatic chk_entry(string nm, int pos, int ecyc, int eaddr, int edata);
        if (pos < wlog.size()) begin
            chk({nm, "_cyc"}, wlog[pos].cyc, ecyc);
            chk({nm, "_addr"}, wlog[pos].addr, eaddr);
            chk({nm, "_data"}, wlog[pos].data, edata);
        end else begin
            chk({nm, "_present"}, 0, 1);
        end
    endtask

    initial begin
        int e, e2, base, b0;
        do_reset();
        chk("rst_address", address, 0);
        chk("rst_writedata", writedata, 0);

        // Empty frame: twelve busy cycles, no writes.
        base = wlog.size(); b0 = busy_total;
        vsync(e);
        tick(20);
        chk("empty_writes", wlog.size() - base, 0);
        chk("empty_busy", busy_total - b0, 12);

        // Two updates, written at E+2 and E+13.
        do_reset();
        upd(0, 8'h37);
        upd(11, 8'h05);
        base = wlog.size();
        vsync(e);
        tick(16);
        chk("two_count", wlog.size() - base, 2);
        chk_entry("two_0", base, e + 2, 0, 32'h37);
        chk_entry("two_11", base + 1, e + 13, 11, 32'h05);

        // force_all replays the power-on values.
        do_reset();
        force_all = 1'b1; tick(1); force_all = 1'b0;
        base = wlog.size();
        vsync(e);
        tick(16);
        chk("force_count", wlog.size() - base, 12);
        for (int i = 0; i < 12; i++) chk_entry("force", base + i, e + 2 + i, i, defaults[i]);

        // Update on the index being scanned: old value now, new value next frame.
        do_reset();
        upd(3, 8'h13); upd(4, 8'h14); upd(5, 8'h15);
        base = wlog.size();
        vga_vs = 1'b0; e = cyc + 1;
        tick(3);
        vga_vs = 1'b1;
        tick(3);
        upd(4, 8'h99);
        tick(12);
        chk("coll_count", wlog.size() - base, 3);
        chk_entry("coll_3", base, e + 5, 3, 32'h13);
        chk_entry("coll_4", base + 1, e + 6, 4, 32'h14);
        chk_entry("coll_5", base + 2, e + 7, 5, 32'h15);
        base = wlog.size();
        vsync(e2);
        tick(16);
        chk("coll_next_count", wlog.size() - base, 1);
        chk_entry("coll_next", base, e2 + 6, 4, 32'h99);

        // Out-of-range addresses are counted and dropped.
        do_reset();
        upd(12, 8'hAA);
        upd(15, 8'hBB);
        tick(1);
        chk("bad_cnt", bad_addr_cnt, 2);
        base = wlog.size();
        vsync(e);
        tick(16);
        chk("bad_writes", wlog.size() - base, 0);

        // Second vsync edge during SCAN is counted, no extra scan.
        do_reset();
        b0 = busy_total;
        vga_vs = 1'b0; e = cyc + 1;
        tick(2);
        vga_vs = 1'b1;
        tick(3);
        vga_vs = 1'b0;
        tick(2);
        vga_vs = 1'b1;
        tick(30);
        chk("ovr_cnt", overrun_cnt, 1);
        chk("ovr_busy", busy_total - b0, 12);

        // Counter saturation.
        do_reset();
        upd_valid = 1'b1; upd_addr = 4'd13;
        tick(300);
        upd_valid = 1'b0;
        tick(1);
        chk("bad_sat", bad_addr_cnt, 255);
        for (int i = 0; i < 1200; i++) begin
            vga_vs = ~vga_vs;
            tick(1);
        end
        vga_vs = 1'b1;
        tick(20);
        chk("ovr_sat", overrun_cnt, 255);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(0, 999) < 3);
            upd_valid = $urandom_range(0, 1);
            upd_addr  = 4'($urandom_range(0, 15));
            upd_data  = 8'($urandom);
            force_all = ($urandom_range(0, 99) < 3);
            if (vga_vs) vga_vs = !($urandom_range(0, 99) < 5);
            else        vga_vs = ($urandom_range(0, 99) < 30);
            tick(1);
        end
        reset = 1'b0; upd_valid = 1'b0; force_all = 1'b0; vga_vs = 1'b1;
        tick(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_reg_writer.md
# vga_reg_writer

Avalon-MM write initiator that drives the sprite/score register map of the VGA sprite peripheral. It keeps a shadow copy of the 12 peripheral registers, accepts value updates from game logic at any time, and flushes only the changed (dirty) registers as single-cycle writes once per frame, starting on the falling edge of VGA vertical sync. Sprites therefore move only between frames and never tear mid-frame. It sits between the game-control logic and the peripheral's `chipselect`/`write`/`address`/`writedata` slave port.

## Interface

Parameters:
- `NUM_REGS`, 12: number of shadowed registers, mapped to peripheral addresses 0..NUM_REGS-1.
- `DATA_W`, 8: significant bits per register; `writedata` is zero-extended to 32 bits.

Ports:
- `clk` input, 1 bit: single clock, the same 50 MHz clock as the peripheral.
- `reset` input, 1 bit: synchronous, active-high.
- `upd_valid` input, 1 bit: update request from game logic.
- `upd_ready` output, 1 bit: update accepted when `upd_valid && upd_ready`.
- `upd_addr` input, 4 bits: register index to update.
- `upd_data` input, DATA_W bits: new register value.
- `force_all` input, 1 bit: one-cycle pulse that marks all registers dirty.
- `vga_vs` input, 1 bit: VGA_VS from the timing generator, active low.
- `chipselect` output, 1 bit: peripheral select, registered.
- `write` output, 1 bit: write strobe, registered, always equal to `chipselect`.
- `address` output, 9 bits: peripheral register address, registered.
- `writedata` output, 32 bits: write data, registered.
- `busy` output, 1 bit: high while the FSM is in SCAN.
- `bad_addr_cnt` output, 8 bits: count of accepted updates with `upd_addr >= NUM_REGS`. Saturates at 255.
- `overrun_cnt` output, 8 bits: count of vsync edges that arrive while in SCAN. Saturates at 255.

## Operation

- State: shadow[0..11] (DATA_W bits each), dirty[0..11], `vs_d` (registered copy of `vga_vs`), FSM state IDLE/SCAN, and a 4-bit index `idx`.
- On reset, the shadow registers load the peripheral's own power-on values truncated to 8 bits: 100, 100, 200, 150, 44, 200, 244, 100, 100, 4, 160, 192. All dirty bits clear, and `vs_d` is set to 1.
- `upd_ready` is tied to 1 whenever `reset` is low, and is 0 during reset.
- For an accepted update with `upd_addr < NUM_REGS`, `shadow[upd_addr]` is set to `upd_data` and `dirty[upd_addr]` is set to 1. For an accepted update with `upd_addr >= NUM_REGS`, the data is dropped and `bad_addr_cnt` increments.
- `force_all` sets every dirty bit.
- Vsync edge: the edge is detected in a cycle where `vs_d == 1 && vga_vs == 0`.
  - IDLE, edge detected: go to SCAN with `idx` = 0.
  - SCAN, edge detected: `overrun_cnt` increments and the edge is otherwise ignored.
- SCAN visits one index per cycle, using a fixed 12-cycle scan with no skipping. For the current `idx = i`:
  - On the next edge, `chipselect` and `write` are set to dirty[i], `address` to i, and `writedata` to {24'b0, shadow[i]}.
  - dirty[i] clears.
  - `idx` increments. If `idx == NUM_REGS-1`, the FSM returns to IDLE.
- Clean registers produce a cycle with `chipselect` = 0. In that cycle `address` and `writedata` still update but are don't-care.
- When an accepted update targets the same i being scanned in that cycle, the old shadow value is written, and on that edge the shadow takes the new value with dirty[i] left at 1. The new value goes out in the next frame.
- An update to an index > `idx` during SCAN is written in the same flush. An update to an index < `idx` is written in the next flush.
- When `force_all` arrives in the same cycle as a scan of i, dirty[i] remains 1.
- Outside SCAN, `chipselect` and `write` are 0.

## Timing

- Reset values of outputs: `chipselect`=0, `write`=0, `address`=0, `writedata`=0, `busy`=0, `upd_ready`=0 (during reset), `bad_addr_cnt`=0, `overrun_cnt`=0.
- Let E be the edge at which the vsync edge is detected:
  - SCAN and `busy` begin at E+1.
  - The write for index i is visible in the cycle following edge E+2+i, for i = 0..11.
  - `busy` drops after edge E+13.
- Update latency: an update accepted at edge U sets shadow and dirty at U. It is written in the first scan cycle for that index occurring after U.
- Reset asserted during SCAN: the FSM goes to IDLE at once, outputs clear at the next edge, and the shadow reloads its defaults. Pending dirty data is lost.

## Test plan

- **Reset, then one vsync edge with no updates** → 12 scan cycles, `chipselect` never high, `busy` high exactly 12 cycles.
- **Update addr 0 = 0x37 and addr 11 = 0x05, then vsync edge at E** → two writes only: address 0 with writedata 0x00000037 at E+2, and address 11 with writedata 0x00000005 at E+13.
- **`force_all`, then vsync** → 12 consecutive writes with addresses 0..11 and data 100, 100, 200, 150, 44, 200, 244, 100, 100, 4, 160, 192.
- **During a flush of dirty 3..5, update addr 4 = 0x99 in the cycle when idx=4** → old value written to address 4. The next frame writes address 4 = 0x99.
- **Update addr 12 and addr 15** → `bad_addr_cnt`=2, no writes on the next flush.
- **Second vsync edge 5 cycles into SCAN** → `overrun_cnt`=1, the scan completes normally in 12 cycles, and no second scan occurs.
